mips_avalon_bridge: RTL and testbench
=====================================

Name: mips_avalon_bridge

Overview:
- Parametrised two-channel bridge between the Harvard core's instruction and data ports and a single Avalon-MM master.
- Arbitrates fetch against load/store and honours waitrequest for any number of cycles.
- Generates byteenable and lane-shifted writedata for sub-word stores, and right-aligns sub-word load data.
- Reports misaligned accesses and bus timeouts instead of hanging the core.

Parameters:
ADDR_W, 32, byte-address width of client and Avalon addresses
DATA_W, 32, bus data width; legal values 32 or 64; BE_W = DATA_W/8, LANE_W = log2(BE_W)
MAX_WAIT, 255, consecutive waitrequest cycles before timeout; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch byte address (word-aligned to DATA_W)
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DATA_W  fetched word, valid while i_ack=1
i_err  out  1  fetch failed (misaligned or timeout), valid with i_ack
d_req  in  1  data request; held with all d_* inputs stable until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data byte address
d_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64)
d_wdata  in  DATA_W  store data, right-aligned
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, right-aligned, extended per Behaviour; valid with d_ack
d_err  out  1  data access failed, valid with d_ack
address  out  ADDR_W  Avalon address, low LANE_W bits forced 0
read  out  1  Avalon read
write  out  1  Avalon write
writedata  out  DATA_W  Avalon write data
byteenable  out  BE_W  Avalon byte enables
waitrequest  in  1  Avalon stall
readdata  in  DATA_W  Avalon read data, valid on the cycle read=1 && waitrequest=0
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- All outputs are registered.
- Reset values: address=0, read=0, write=0, writedata=0, byteenable=0, i_ack=0, d_ack=0, i_err=0, d_err=0, i_rdata=0, d_rdata=0, busy=0, timeout_err=0.
- Reset asserted mid-transfer drops read/write at that edge; the pending request is abandoned and no ack is issued.
- FSM states:
  - IDLE: grant evaluated each cycle. Data has priority over fetch: if d_req, take the data channel, else if i_req, take the fetch channel.
  - At grant: latch channel, address, size, we and shifted wdata.
  - Misaligned grant → RESP with err=1, no bus cycle. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0; dword when DATA_W=32; fetch with low LANE_W bits ≠0.
  - Aligned grant → BUS.
  - BUS: read or write held high with address/byteenable/writedata stable.
  - Waiting: wait counter increments on every cycle with waitrequest=1.
  - Completion: waitrequest=0 → capture readdata (loads/fetches), drop read/write, go to RESP.
  - Timeout: counter reaching MAX_WAIT (MAX_WAIT>0) → drop read/write, set timeout_err, go to RESP with err=1.
  - RESP: ack pulses for exactly one cycle on the granted channel with rdata/err, then IDLE.
  - No grant is made in RESP, so a request still high during its ack is never re-served.
- Latency: aligned access with zero wait states = grant edge + 1 bus cycle, ack on the 3rd cycle after req is first sampled in IDLE; each wait cycle adds 1. Misaligned: ack 2 cycles after grant.
- Lane rules, with lane = addr[LANE_W-1:0]:
  - byteenable = ((1<<bytes)-1) << lane, where bytes = 1<<size.
  - writedata = d_wdata << (8*lane); bytes outside the enabled lanes are 0.
  - Load: d_rdata = (readdata >> (8*lane)) masked to size and zero-extended.
  - Fetch: byteenable all ones; i_rdata = readdata unmodified.
- Simultaneous i_req and d_req in IDLE: data is served first; fetch is granted in the IDLE after the data RESP. No starvation, since the core issues at most one data access per instruction.
- waitrequest is ignored outside BUS.

Optional Feature:
- Macro MIPS_BRIDGE_SEXT_EN.
- Defined: adds input port d_signed (1 bit, held with d_req). Loads with d_signed=1 and size<max sign-extend from the top loaded bit; d_signed=0 zero-extends.
- Undefined: port absent; all loads zero-extend.

Test Plan:
- Fetch, i_addr=0x0000_0040, waitrequest=0, readdata=0x2402_0005 → read=1, address=0x40, byteenable=4'b1111 for 1 cycle; i_ack=1, i_rdata=0x2402_0005, i_err=0 three cycles after req.
- Store byte d_addr=0x103, d_wdata=0xAB, waitrequest high 4 cycles → write held 5 cycles, address=0x100, byteenable=4'b1000, writedata=0xAB00_0000; single d_ack.
- Load half d_addr=0x202, readdata=0x8001_FFFF → d_rdata=0x0000_8001 (macro off); with MIPS_BRIDGE_SEXT_EN and d_signed=1 → 0xFFFF_8001.
- i_req and d_req raised same cycle → data bus cycle first, d_ack, then fetch bus cycle, i_ack; never both acks in one cycle.
- Word load d_addr=0x101 → no read asserted, d_ack=1 with d_err=1 two cycles after grant.
- MAX_WAIT=8, waitrequest stuck 1 → read drops after 8 wait cycles, d_err=1, timeout_err stays 1 until reset; reset mid-BUS clears read next edge with no ack.

Source files
------------

// File: rtl/mips_avalon_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_avalon_bridge - arbitrates core fetch/data ports onto one Avalon-MM
// master. Define MIPS_BRIDGE_SEXT_EN to add d_signed (sign-extended loads).
// Revision: 1.0
// ---------------------------------------------------------------------------
module mips_avalon_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
`ifdef MIPS_BRIDGE_SEXT_EN
  input  logic              d_signed,
`endif
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              chan, chan_nxt;
  logic [LANE_W-1:0] lane, lane_nxt;
  logic [1:0]        size, size_nxt;
  logic              sgn, sgn_nxt;
  logic [31:0]       wcnt, wcnt_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic              read_nxt, write_nxt, busy_nxt, timeout_err_nxt;
  logic [DATA_W-1:0] writedata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic [BE_W-1:0]   byteenable_nxt;
  logic              i_ack_nxt, d_ack_nxt, i_err_nxt, d_err_nxt;

  logic              signed_req;
`ifdef MIPS_BRIDGE_SEXT_EN
  assign signed_req = d_signed;
`else
  assign signed_req = 1'b0;
`endif

  // Grant-side decode: data wins over fetch whenever both are requesting.
  logic [ADDR_W-1:0] g_addr;
  logic [LANE_W-1:0] g_lane;
  logic [1:0]        g_size;
  logic              g_mis;
  logic [BE_W-1:0]   g_bmask, g_be;
  logic [DATA_W-1:0] g_wmask, g_wdata;

  always_comb begin
    g_addr = d_req ? d_addr : i_addr;
    g_lane = g_addr[LANE_W-1:0];
    g_size = d_req ? d_size : 2'(LANE_W);
    g_mis  = 1'b0;
    if (d_req) begin
      case (d_size)
        2'd1:    g_mis = g_addr[0];
        2'd2:    g_mis = |g_addr[1:0];
        2'd3:    g_mis = (DATA_W == 32) || (|g_addr[2:0]);
        default: g_mis = 1'b0;
      endcase
    end else begin
      g_mis = |g_lane;
    end
    for (int b = 0; b < BE_W; b++) g_bmask[b] = (b < (1 << g_size));
    g_be = d_req ? (g_bmask << g_lane) : '1;
    for (int b = 0; b < BE_W; b++) g_wmask[8*b +: 8] = {8{g_be[b]}};
    g_wdata = (d_wdata << {g_lane, 3'b000}) & g_wmask;
  end

  // Load alignment: shift the addressed lanes down, mask to size, extend.
  logic [DATA_W-1:0] ld_shift, ld_mask, ld_val;
  logic              ld_top;

  always_comb begin
    ld_shift = readdata >> {lane, 3'b000};
    for (int i = 0; i < DATA_W; i++) ld_mask[i] = (i < (8 << size));
    ld_top = |(ld_shift & ld_mask & ~(ld_mask >> 1));
    ld_val = (ld_shift & ld_mask) | ((sgn && ld_top) ? ~ld_mask : '0);
  end

  logic wait_hit;
  assign wait_hit = (MAX_WAIT != 0) && ((wcnt + 32'd1) == 32'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      chan        <= 1'b0;
      lane        <= '0;
      size        <= 2'd0;
      sgn         <= 1'b0;
      wcnt        <= 32'd0;
      address     <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= '0;
      byteenable  <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_err       <= 1'b0;
      d_err       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      chan        <= chan_nxt;
      lane        <= lane_nxt;
      size        <= size_nxt;
      sgn         <= sgn_nxt;
      wcnt        <= wcnt_nxt;
      address     <= address_nxt;
      read        <= read_nxt;
      write       <= write_nxt;
      writedata   <= writedata_nxt;
      byteenable  <= byteenable_nxt;
      i_ack       <= i_ack_nxt;
      d_ack       <= d_ack_nxt;
      i_err       <= i_err_nxt;
      d_err       <= d_err_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (d_req || i_req) state_nxt = g_mis ? S_RESP : S_BUS;
      S_BUS:   if (!waitrequest || wait_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    chan_nxt        = chan;
    lane_nxt        = lane;
    size_nxt        = size;
    sgn_nxt         = sgn;
    wcnt_nxt        = wcnt;
    address_nxt     = address;
    read_nxt        = read;
    write_nxt       = write;
    writedata_nxt   = writedata;
    byteenable_nxt  = byteenable;
    i_rdata_nxt     = i_rdata;
    d_rdata_nxt     = d_rdata;
    timeout_err_nxt = timeout_err;
    i_ack_nxt       = 1'b0;
    d_ack_nxt       = 1'b0;
    i_err_nxt       = 1'b0;
    d_err_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_req || i_req) begin
          chan_nxt       = d_req;
          lane_nxt       = g_lane;
          size_nxt       = g_size;
          sgn_nxt        = d_req && signed_req;
          wcnt_nxt       = 32'd0;
          address_nxt    = g_addr & ~ADDR_W'(BE_W - 1);
          byteenable_nxt = g_be;
          writedata_nxt  = d_req ? g_wdata : '0;
          if (g_mis) begin
            d_ack_nxt = d_req;
            d_err_nxt = d_req;
            i_ack_nxt = !d_req;
            i_err_nxt = !d_req;
          end else begin
            read_nxt  = !(d_req && d_we);
            write_nxt = d_req && d_we;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          d_ack_nxt = chan;
          i_ack_nxt = !chan;
          if (chan && read) d_rdata_nxt = ld_val;
          if (!chan)        i_rdata_nxt = readdata;
        end else if (wait_hit) begin
          read_nxt        = 1'b0;
          write_nxt       = 1'b0;
          timeout_err_nxt = 1'b1;
          d_ack_nxt       = chan;
          d_err_nxt       = chan;
          i_ack_nxt       = !chan;
          i_err_nxt       = !chan;
        end else begin
          wcnt_nxt = wcnt + 32'd1;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_avalon_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_avalon_bridge - directed plus random transactions against a
// byte-level reference model of the bridge.
// ---------------------------------------------------------------------------
module tb_mips_avalon_bridge;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, waitrequest = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
  logic [1:0]  d_size = '0;
  logic        i_ack, i_err, d_ack, d_err, read, write, busy, timeout_err;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
`ifdef MIPS_BRIDGE_SEXT_EN
  logic        d_signed = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit sticky = 0;

  mips_avalon_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
`ifdef MIPS_BRIDGE_SEXT_EN
    .d_signed(d_signed),
`endif
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: natural alignment, byte-by-byte lane placement and extraction.
  task automatic model(input bit isd, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input logic [31:0] rd, input bit sg,
                       output bit mis, output logic [3:0] be,
                       output logic [31:0] ewd, output logic [31:0] erd);
    int lane, nb;
    bit sx;
    lane = int'(addr % 4);
    nb   = 1 << size;
`ifdef MIPS_BRIDGE_SEXT_EN
    sx = sg;
`else
    sx = 1'b0 & sg;
`endif
    be = '0; ewd = '0; erd = '0;
    if (!isd) begin
      mis = (lane != 0);
      be  = 4'hF;
      erd = rd;
    end else begin
      mis = (size == 2'd3) || ((addr % nb) != 0);
      if (!mis) begin
        for (int b = 0; b < nb; b++) begin
          be[lane+b]            = 1'b1;
          ewd[8*(lane+b) +: 8]  = wd[8*b +: 8];
          erd[8*b +: 8]         = rd[8*(lane+b) +: 8];
        end
        if (sx && nb < 4 && erd[8*nb-1])
          for (int b = nb; b < 4; b++) erd[8*b +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic txn(input bit isd, input bit we, input logic [31:0] addr, input logic [1:0] size,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits, input bit sg);
    bit mis, to, done;
    logic [3:0] be;
    logic [31:0] ewd, erd;
    int k, nbus, ek, ebus;
    model(isd, addr, size, wd, rd, sg && isd && !we, mis, be, ewd, erd);
    to   = !mis && waits >= MAXW;
    ek   = mis ? 1 : (to ? MAXW + 1 : waits + 2);
    ebus = mis ? 0 : (to ? MAXW : waits + 1);
    if (isd) begin
      d_we = we; d_addr = addr; d_size = size; d_wdata = wd; d_req = 1'b1;
`ifdef MIPS_BRIDGE_SEXT_EN
      d_signed = sg;
`endif
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    k = 0; nbus = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clk); k++;
      if (read || write) begin
        nbus++;
        check("bus_rw", {read, write}, {!(isd && we), isd && we});
        check("bus_addr", address, addr & ~32'h3);
        check("bus_be", byteenable, be);
        check("bus_busy", busy, 1);
        if (isd && we) check("bus_wdata", writedata, ewd);
        waitrequest = (nbus <= waits);
        readdata    = rd;
      end else begin
        waitrequest = 1'($urandom);
        readdata    = $urandom;
      end
      if (i_ack || d_ack) begin
        done = 1;
        check("ack_chan", {i_ack, d_ack}, {!isd, isd});
        check("ack_cycle", k, ek);
        check("bus_cycles", nbus, ebus);
        check("err", isd ? d_err : i_err, mis || to);
        if (!mis && !to && !(isd && we)) check("rdata", isd ? d_rdata : i_rdata, erd);
        if (to) sticky = 1;
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    check("ack_seen", done, 1);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("idle_after", {i_ack, d_ack, busy, read, write}, 0);
    check("timeout_err", timeout_err, sticky);
  endtask

  initial begin
    int k, nb;
    bit sd, si;
    logic [1:0] sz;
    logic [31:0] a;
    int w;

    repeat (3) @(negedge clk);
    check("rst_a", {address, writedata}, 0);
    check("rst_b", {i_rdata, d_rdata}, 0);
    check("rst_c", {read, write, byteenable, i_ack, d_ack, i_err, d_err, busy, timeout_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    txn(0, 0, 32'h40, 2'd2, 32'h0, 32'h2402_0005, 0, 0);
    txn(1, 1, 32'h103, 2'd0, 32'hAB, 32'h0, 4, 0);
    txn(1, 0, 32'h202, 2'd1, 32'h0, 32'h8001_FFFF, 0, 1);
    txn(1, 0, 32'h202, 2'd1, 32'h0, 32'h8001_FFFF, 1, 0);

    // Simultaneous fetch and data request: data first, then fetch.
    d_we = 0; d_addr = 32'h300; d_size = 2'd2; i_addr = 32'h500; waitrequest = 0;
    d_req = 1; i_req = 1;
    k = 0; nb = 0; sd = 0; si = 0;
    while (!si && k < 30) begin
      @(negedge clk); k++;
      waitrequest = 1'b0;
      if (read) begin
        if (nb == 0) check("sim_first_bus", address, 32'h300);
        readdata = (address == 32'h300) ? 32'hDDDD_0001 : 32'h1111_0002;
        nb++;
      end
      if (i_ack || d_ack) check("sim_ack_onehot", i_ack & d_ack, 0);
      if (d_ack) begin
        sd = 1; d_req = 0;
        check("sim_d_cycle", k, 2);
        check("sim_d_rdata", d_rdata, 32'hDDDD_0001);
      end
      if (i_ack) begin
        si = 1; i_req = 0;
        check("sim_i_cycle", k, 5);
        check("sim_i_rdata", i_rdata, 32'h1111_0002);
      end
    end
    check("sim_done", {sd, si}, 2'b11);
    check("sim_bus_count", nb, 2);
    i_req = 0; d_req = 0;
    @(negedge clk);

    txn(1, 0, 32'h101, 2'd2, 32'h0, 32'hFFFF_FFFF, 0, 0);
    txn(0, 0, 32'h42, 2'd2, 32'h0, 32'h1234_5678, 0, 0);
    txn(1, 0, 32'h600, 2'd2, 32'h0, 32'h5555_AAAA, 100, 0);
    txn(1, 1, 32'h604, 2'd1, 32'h1234_BEEF, 32'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      w  = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        txn(0, 0, ($urandom_range(0, 3) == 0) ? a : (a & ~32'h3), 2'd2, 32'h0, $urandom, w, 0);
      else
        txn(1, 1'($urandom), a, sz, $urandom, $urandom, w, 1'($urandom));
    end

    // Reset in the middle of a stalled bus cycle abandons the request.
    d_we = 0; d_addr = 32'h400; d_size = 2'd2; d_req = 1; waitrequest = 1;
    k = 0;
    while (!read && k < 5) begin @(negedge clk); k++; waitrequest = 1; end
    check("rstbus_read_up", read, 1);
    @(negedge clk);
    reset = 1; d_req = 0;
    @(negedge clk);
    check("rstbus_read", {read, write, busy}, 0);
    check("rstbus_ack", {i_ack, d_ack}, 0);
    check("rstbus_sticky", timeout_err, 0);
    reset = 0; sticky = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rstbus_noack", {i_ack, d_ack, read, write}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
